hilo_div_ctrl: RTL

- Execute-stage initiator for the iterative divider. Accepts a DIV request from the pipeline, launches the divider, and holds the operands and begin strobe stable until the divider reports completion.
- On completion, writes the quotient to LO and the sign-corrected remainder to HI.
- Owns the HI/LO registers, including MTHI/MTLO writes and the pipeline stall while a division is in flight.

---
 rtl/hilo_div_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/hilo_div_ctrl.sv
// Execute-stage initiator for the iterative divider; owns HI/LO and the DIV pipeline stall.
// Holds operands and begin stable until the divider's completion pulse.
module hilo_div_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_req,
    input  logic [31:0] div_a,
    input  logic [31:0] div_b,
    input  logic        flush,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] hi_wdata,
    input  logic [31:0] lo_wdata,
    output logic        div_begin,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    input  logic [31:0] div_result,
    input  logic [31:0] div_remainder,
    input  logic        div_end,
    output logic        stall,
    output logic        div_zero,
    output logic [31:0] hi_rdata,
    output logic [31:0] lo_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        begin_q, begin_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        zero_q, zero_d;
    logic        b_nonzero;

    assign b_nonzero = (div_b != 32'd0);

    always_comb begin
        state_d = state_q;
        begin_d = begin_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        zero_d  = 1'b0;
        stall   = 1'b0;
        if (flush) begin
            state_d = IDLE;
            begin_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mthi_we) hi_d = hi_wdata;
                    if (mtlo_we) lo_d = lo_wdata;
                    if (div_req) begin
                        if (b_nonzero) begin
                            op1_d   = div_a;
                            op2_d   = div_b;
                            begin_d = 1'b1;
                            state_d = BUSY;
                            stall   = 1'b1;
                        end else begin
                            zero_d = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // Release the stall in the div_end cycle so the DIV retires with its result.
                    stall = ~div_end;
                    if (div_end) begin
                        lo_d    = div_result;
                        hi_d    = op1_q[31] ? (32'd0 - div_remainder) : div_remainder;
                        begin_d = 1'b0;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    // One guaranteed begin-low cycle before any relaunch.
                    if (mthi_we) hi_d = hi_wdata;
                    if (mtlo_we) lo_d = lo_wdata;
                    stall   = div_req;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    begin_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            begin_q <= 1'b0;
            op1_q   <= 32'd0;
            op2_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            begin_q <= begin_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            zero_q  <= zero_d;
        end
    end

    assign div_begin = begin_q;
    assign div_op1   = op1_q;
    assign div_op2   = op2_q;
    assign div_zero  = zero_q;
    assign hi_rdata  = hi_q;
    assign lo_rdata  = lo_q;

endmodule
